// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and types for the BCD seven-segment scanner.
//   - Active-low segment patterns ordered {g,f,e,d,c,b,a}
//   - Scan state typedef (BLANK, DRIVE)
//   - MIN_REFRESH_DIV: shortest legal slot (1 blank cycle + 1 drive cycle)
package seg_scan_pkg;

  localparam int MIN_REFRESH_DIV = 2;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low seven-segment decoder.
//   bcd  in  4  BCD digit; 10..15 render as a dash
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: time-multiplexed common-anode seven-segment driver.
// Captures DIGITS BCD digits on load and scans one digit per REFRESH_DIV-cycle
// slot, with a single all-off cycle at the start of each slot to avoid ghosting.
//
// Ports:
//   clk     in   1         rising-edge clock
//   rst     in   1         asynchronous active-high reset
//   bcd_in  in   4*DIGITS  packed digits, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in   in   DIGITS    decimal point request per digit, active-high
//   load    in   1         capture bcd_in/dp_in into the shadow registers
//   blank   in   1         force all anodes off; scanning keeps running
//   seg     out  7         {g,f,e,d,c,b,a}, active-low, registered
//   dp      out  1         decimal point, active-low, registered
//   an      out  DIGITS    anode enables, active-low, registered
//   frame   out  1         one-cycle pulse when the scan wraps to digit 0
//
// Build option: define LEADING_ZERO_BLANK_EN to suppress leading zero digits
// (digit 0 is always shown; dp and anode scanning are unaffected).
//
// state | meaning
// BLANK | one cycle with all anodes off before the indexed digit is driven
// DRIVE | indexed digit on the pins, re-decoded every cycle until tick
module bcd_seg_scanner
  import seg_scan_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  // A slot shorter than MIN_REFRESH_DIV would leave no drive cycle.
  localparam int DIV = (REFRESH_DIV < MIN_REFRESH_DIV) ? MIN_REFRESH_DIV : REFRESH_DIV;
  localparam int PW  = $clog2(DIV);
  localparam int IW  = $clog2(DIGITS);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  scan_state_t       state, state_nxt;
  logic [PW-1:0]     pre, pre_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [3:0]        shadow [DIGITS];
  logic [DIGITS-1:0] shadow_dp;

  logic [6:0]        seg_nxt;
  logic              dp_nxt;
  logic [DIGITS-1:0] an_nxt;
  logic              frame_nxt;

  logic              tick;
  logic [6:0]        dec_seg;
  logic [6:0]        digit_seg;
  logic [DIGITS-1:0] an_sel;

  assign tick   = (pre == PRE_LAST);
  assign an_sel = ~(DIGITS'(1) << idx);

  bcd_to_seg u_dec (
    .bcd (shadow[idx]),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;

  // Walk down from the most significant digit; a digit is a leading zero
  // while it and every digit above it are zero.
  always_comb begin
    logic zero_run;
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run && (shadow[i] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  assign digit_seg = lead_zero[idx] ? SEG_OFF : dec_seg;
`else
  assign digit_seg = dec_seg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BLANK;
      pre       <= '0;
      idx       <= '0;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
      an        <= '1;
      frame     <= 1'b0;
      shadow_dp <= '0;
      for (int i = 0; i < DIGITS; i++) shadow[i] <= 4'd0;
    end else begin
      state <= state_nxt;
      pre   <= pre_nxt;
      idx   <= idx_nxt;
      seg   <= seg_nxt;
      dp    <= dp_nxt;
      an    <= an_nxt;
      frame <= frame_nxt;
      if (load) begin
        shadow_dp <= dp_in;
        for (int i = 0; i < DIGITS; i++) shadow[i] <= bcd_in[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pre_nxt   = tick ? '0 : pre + 1'b1;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;
    an_nxt    = '1;
    frame_nxt = 1'b0;

    case (state)
      BLANK: begin
        state_nxt = DRIVE;
        seg_nxt   = digit_seg;
        dp_nxt    = ~shadow_dp[idx];
        an_nxt    = an_sel;
      end
      DRIVE: begin
        if (tick) begin
          state_nxt = BLANK;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          frame_nxt = (idx == IDX_LAST);
        end else begin
          seg_nxt = digit_seg;
          dp_nxt  = ~shadow_dp[idx];
          an_nxt  = an_sel;
        end
      end
      default: state_nxt = BLANK;
    endcase

    // Blanking only gates the anodes; segment data keeps tracking the scan.
    if (blank) an_nxt = '1;
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb_bcd_seg_scanner: self-checking bench for bcd_seg_scanner (DIGITS=4,
// REFRESH_DIV=4). Expected pin values come from the slot arithmetic of the
// scan: after edge k (counted from reset release) the slot is (k-1)/RD, the
// last cycle of each slot is the blank gap, and frame fires every ND*RD edges.
module tb_bcd_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   bcd_in = '0;
  logic [3:0]    dp_in = '0;
  logic          load = 1'b0;
  logic          blank = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame;

  int checks = 0;
  int failures = 0;
  int k = 0;

  logic [15:0] m_shadow = '0;
  logic [3:0]  m_dp = '0;
  logic [15:0] prev_shadow = '0;
  logic [3:0]  prev_dp = '0;
  logic        prev_blank = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  bcd_seg_scanner #(.DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk    (clk),
    .rst    (rst),
    .bcd_in (bcd_in),
    .dp_in  (dp_in),
    .load   (load),
    .blank  (blank),
    .seg    (seg),
    .dp     (dp),
    .an     (an),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_frame"}, 32'(frame), 32'h0);
  endtask

  task automatic check_model();
    int d;
    bit off;
    logic [3:0] dig;
    logic [6:0] e_seg;
    logic e_dp;
    logic [3:0] e_an;
    off = (k % RD == 0);
    d = ((k - 1) / RD) % ND;
    dig = prev_shadow[4*d +: 4];
    e_seg = seg_tab[dig];
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 0 && (prev_shadow >> (4*d)) == 16'h0) e_seg = 7'b1111111;
`endif
    if (off) begin
      e_seg = 7'b1111111;
      e_dp  = 1'b1;
      e_an  = 4'hF;
    end else begin
      e_dp = ~prev_dp[d];
      e_an = ~(4'b0001 << d);
    end
    if (prev_blank) e_an = 4'hF;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame", 32'(frame), 32'((k % (RD*ND)) == 0));
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic step();
    prev_shadow = m_shadow;
    prev_dp     = m_dp;
    prev_blank  = blank;
    @(posedge clk);
    k++;
    if (load) begin
      m_shadow = bcd_in;
      m_dp     = dp_in;
    end
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held: outputs at reset values.
    repeat (2) @(negedge clk);
    check_reset_state("rst_hold");
    rst = 1'b0;
    k = 0;
    m_shadow = '0;
    m_dp = '0;

    // Idle scan with zero shadow: slot pattern and frame period.
    run(40);

    // Mixed digits with one decimal point.
    bcd_in = 16'h1259; dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    run(20);

    // Dash plus leading zeros.
    bcd_in = 16'h00A3; dp_in = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    run(20);

    // Load on the tick edge: next digit must show new data after its blank.
    for (int i = 0; i < RD && ((k + 1) % RD) != 0; i++) step();
    chk("tick_align", 32'((k + 1) % RD), 32'h0);
    bcd_in = 16'h8765; dp_in = 4'b1010; load = 1'b1;
    step();
    load = 1'b0;
    run(10);

    // Blank held for 10 cycles mid-frame, then release.
    run(3);
    blank = 1'b1;
    run(10);
    blank = 1'b0;
    run(8);

    // Randomized loads and blanking.
    for (int i = 0; i < 300; i++) begin
      load   = ($urandom_range(9) == 0);
      bcd_in = 16'($urandom);
      dp_in  = 4'($urandom);
      blank  = ($urandom_range(6) == 0);
      step();
    end
    load = 1'b0;
    blank = 1'b0;
    bcd_in = 16'h4321; dp_in = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;
    run(6);

    // Asynchronous reset in the middle of digit 2's drive phase.
    for (int i = 0; i < RD*ND && (k % (RD*ND)) != 9; i++) step();
    chk("rst_align", 32'(k % (RD*ND)), 32'd9);
    chk("pre_rst_an", 32'(an), 32'hB);
    #2 rst = 1'b1;
    #1 check_reset_state("rst_async");
    @(negedge clk);
    check_reset_state("rst_held2");
    rst = 1'b0;
    k = 0;
    m_shadow = '0;
    m_dp = '0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
